// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bus: ROM address/data, execute-side redirect controls,
// and the instruction presented to decode/execute.
interface pc_fetch_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 12
);
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_q;
  logic              stall;
  logic              jump;
  logic              call;
  logic              ret;
  logic [ADDR_W-1:0] jump_target;
  logic              skip;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              stack_ovf;
  logic              stack_unf;

  // Fetch unit side
  modport master (
    input  rom_q, stall, jump, call, ret, jump_target, skip,
    output rom_addr, instr, instr_pc, instr_valid, stack_ovf, stack_unf
  );

  // ROM / execute side
  modport slave (
    output rom_q, stall, jump, call, ret, jump_target, skip,
    input  rom_addr, instr, instr_pc, instr_valid, stack_ovf, stack_unf
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage: program counter, return stack and ROM address
// generation. The ROM latches rom_addr on each edge, and fetch_addr_q latches
// the same value, so rom_q always holds the word for instr_pc.
module pc_fetch_unit #(
  parameter int ADDR_W      = 11,
  parameter int DATA_W      = 12,
  parameter int RESET_VEC   = 2047,
  parameter int STACK_DEPTH = 2,
  parameter int NOP_WORD    = 0
) (
  input  logic       clock,
  input  logic       reset,
  pc_fetch_if.master fetch_bus
);

  localparam int                DEPTH_W    = $clog2(STACK_DEPTH + 1);
  localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_VEC);
  localparam logic [DATA_W-1:0] NOP_INSTR  = DATA_W'(NOP_WORD);
  localparam logic [DEPTH_W-1:0] FULL_DEPTH = DEPTH_W'(STACK_DEPTH);

  logic [ADDR_W-1:0]                  fetch_addr_q, fetch_addr_d;
  logic                               valid_q, valid_d;
  logic [STACK_DEPTH-1:0][ADDR_W-1:0] stack_q, stack_d;
  logic [DEPTH_W-1:0]                 depth_q, depth_d;
  logic                               ovf_q, ovf_d;
  logic                               unf_q, unf_d;

  logic              instr_valid_s;
  logic              ret_s;
  logic              jump_s;
  logic              push_s;
  logic              pop_s;
  logic [ADDR_W-1:0] seq_addr_s;

  // Redirects only count for an architectural word and never while stalled;
  // ret wins over jump/call when both are raised.
  assign instr_valid_s = valid_q & ~reset;
  assign ret_s         = fetch_bus.ret  & instr_valid_s & ~fetch_bus.stall;
  assign jump_s        = fetch_bus.jump & instr_valid_s & ~fetch_bus.stall & ~fetch_bus.ret;
  assign push_s        = jump_s & fetch_bus.call;
  assign pop_s         = ret_s;
  assign seq_addr_s    = fetch_addr_q + ADDR_W'(1);

  // Next fetch address by priority: reset, stall, return, jump, sequential.
  always_comb begin
    fetch_addr_d = seq_addr_s;
    if (reset) begin
      fetch_addr_d = RESET_ADDR;
    end else if (fetch_bus.stall) begin
      fetch_addr_d = fetch_addr_q;
    end else if (ret_s) begin
      fetch_addr_d = stack_q[0];
    end else if (jump_s) begin
      fetch_addr_d = fetch_bus.jump_target;
    end else begin
      fetch_addr_d = seq_addr_s;
    end
  end

  // Valid flag for the word fetched this edge: a skip squashes it.
  always_comb begin
    valid_d = 1'b1;
    if (fetch_bus.stall) begin
      valid_d = valid_q;
    end else if (fetch_bus.skip) begin
      valid_d = 1'b0;
    end else begin
      valid_d = 1'b1;
    end
  end

  // Return stack: pop shifts up and duplicates the bottom entry, push shifts
  // down and drops the oldest; depth saturates and misuse sets sticky flags.
  always_comb begin
    stack_d = stack_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (pop_s) begin
      for (int i = 0; i < STACK_DEPTH - 1; i++) begin
        stack_d[i] = stack_q[i+1];
      end
      if (depth_q == {DEPTH_W{1'b0}}) begin
        unf_d = 1'b1;
      end else begin
        depth_d = depth_q - DEPTH_W'(1);
      end
    end else if (push_s) begin
      for (int i = 1; i < STACK_DEPTH; i++) begin
        stack_d[i] = stack_q[i-1];
      end
      stack_d[0] = seq_addr_s;
      if (depth_q == FULL_DEPTH) begin
        ovf_d = 1'b1;
      end else begin
        depth_d = depth_q + DEPTH_W'(1);
      end
    end else begin
      stack_d = stack_q;
    end
  end

  // State registers with synchronous reset to the reset vector.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_addr_q <= RESET_ADDR;
      valid_q      <= 1'b1;
      stack_q      <= '0;
      depth_q      <= {DEPTH_W{1'b0}};
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
    end else begin
      fetch_addr_q <= fetch_addr_d;
      valid_q      <= valid_d;
      stack_q      <= stack_d;
      depth_q      <= depth_d;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
    end
  end

  assign fetch_bus.rom_addr    = fetch_addr_d;
  assign fetch_bus.instr_pc    = fetch_addr_q;
  assign fetch_bus.instr_valid = instr_valid_s;
  assign fetch_bus.instr       = instr_valid_s ? fetch_bus.rom_q : NOP_INSTR;
  assign fetch_bus.stack_ovf   = ovf_q;
  assign fetch_bus.stack_unf   = unf_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: a ROM model, a directed walk through the
// documented scenarios with literal expectations, then randomized traffic,
// all checked every cycle against a behavioural model of the fetch stage.
module tb_pc_fetch_unit;
  localparam int AW = 11;
  localparam int DW = 12;

  logic clock = 1'b0;
  logic reset;

  pc_fetch_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  pc_fetch_unit #(
    .ADDR_W(AW), .DATA_W(DW), .RESET_VEC(2047), .STACK_DEPTH(2), .NOP_WORD(0)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .fetch_bus(bus)
  );

  always #5 clock = ~clock;

  // Synchronous program ROM
  logic [DW-1:0] rom_mem [0:2047];
  always @(posedge clock) bus.rom_q <= rom_mem[bus.rom_addr];

  // Behavioural model state
  int m_pc;
  bit m_valid;
  bit m_known;
  int m_stk[$];
  int m_depth;
  bit m_ovf;
  bit m_unf;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Where the model says the next fetch goes, given the present inputs.
  function automatic int next_addr();
    bit v;
    v = m_valid && !reset;
    if (reset) return 2047;
    if (bus.stall) return m_pc;
    if (bus.ret && v) return m_stk[0];
    if (bus.jump && v) return int'(bus.jump_target);
    return (m_pc + 1) % 2048;
  endfunction

  // Advance the model across one clock edge using the held inputs.
  task automatic model_update();
    int nxt;
    if (reset) begin
      m_pc = 2047; m_valid = 1'b1; m_stk = '{0, 0};
      m_depth = 0; m_ovf = 1'b0; m_unf = 1'b0; m_known = 1'b1;
    end else if (m_known && !bus.stall) begin
      nxt = next_addr();
      if (bus.ret && m_valid) begin
        if (m_depth == 0) m_unf = 1'b1; else m_depth--;
        void'(m_stk.pop_front());
        m_stk.push_back(m_stk[$]);
      end else if (bus.jump && bus.call && m_valid) begin
        m_stk.push_front((m_pc + 1) % 2048);
        void'(m_stk.pop_back());
        if (m_depth == 2) m_ovf = 1'b1; else m_depth++;
      end
      m_pc = nxt;
      m_valid = !bus.skip;
    end
  endtask

  task automatic compare();
    bit v;
    if (m_known) begin
      v = m_valid && !reset;
      chk("rom_addr", 32'(bus.rom_addr), 32'(next_addr()));
      chk("instr_valid", 32'(bus.instr_valid), 32'(v));
      chk("instr_pc", 32'(bus.instr_pc), 32'(m_pc));
      chk("instr", 32'(bus.instr), v ? 32'(rom_mem[m_pc]) : 32'd0);
      chk("stack_ovf", 32'(bus.stack_ovf), 32'(m_ovf));
      chk("stack_unf", 32'(bus.stack_unf), 32'(m_unf));
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_update();
    @(negedge clock);
  endtask

  task automatic apply(input bit r, input bit st, input bit j, input bit c,
                       input bit rt, input int tgt, input bit sk);
    reset = r; bus.stall = st; bus.jump = j; bus.call = c;
    bus.ret = rt; bus.jump_target = tgt[AW-1:0]; bus.skip = sk;
    #1;
    compare();
  endtask

  task automatic drive(input bit r, input bit st, input bit j, input bit c,
                       input bit rt, input int tgt, input bit sk);
    tick();
    apply(r, st, j, c, rt, tgt, sk);
  endtask

  // Directed scenarios, then randomized traffic
  initial begin
    bit r, st, j, c, rt, sk, v;
    int tgt;
    m_known = 1'b0; m_valid = 1'b0; m_pc = 0; m_depth = 0;
    m_ovf = 1'b0; m_unf = 1'b0; m_stk = '{0, 0};
    for (int i = 0; i < 2048; i++) rom_mem[i] = DW'($urandom);
    rom_mem[2047] = 12'hA00;
    reset = 1'b1; bus.stall = 1'b0; bus.jump = 1'b0; bus.call = 1'b0;
    bus.ret = 1'b0; bus.jump_target = '0; bus.skip = 1'b0;

    // Reset held three cycles
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0);
      chk("lit_reset_rom_addr", 32'(bus.rom_addr), 32'h7FF);
      chk("lit_reset_valid", 32'(bus.instr_valid), 32'd0);
      chk("lit_reset_instr", 32'(bus.instr), 32'd0);
    end
    // First word after release, then free run
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("lit_first_instr", 32'(bus.instr), 32'hA00);
    chk("lit_first_pc", 32'(bus.instr_pc), 32'h7FF);
    chk("lit_first_valid", 32'(bus.instr_valid), 32'd1);
    chk("lit_first_rom_addr", 32'(bus.rom_addr), 32'h000);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("lit_freerun_pc", 32'(bus.instr_pc), 32'(i));
    end
    // Jump with no bubble
    drive(0, 0, 1, 0, 0, 'h1E5, 0);
    drive(0, 0, 1, 0, 0, 'h1F8, 0);
    chk("lit_jump_src_pc", 32'(bus.instr_pc), 32'h1E5);
    chk("lit_jump_rom_addr", 32'(bus.rom_addr), 32'h1F8);
    drive(0, 0, 1, 0, 0, 'h1E1, 0);
    chk("lit_jump_dst_pc", 32'(bus.instr_pc), 32'h1F8);
    chk("lit_jump_dst_valid", 32'(bus.instr_valid), 32'd1);
    // Call and return
    drive(0, 0, 1, 1, 0, 'h200, 0);
    chk("lit_call_pc", 32'(bus.instr_pc), 32'h1E1);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("lit_callee_pc", 32'(bus.instr_pc), 32'h200);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("lit_ret_pc", 32'(bus.instr_pc), 32'h202);
    chk("lit_ret_rom_addr", 32'(bus.rom_addr), 32'h1E2);
    // Three nested calls overflow a two-entry stack
    drive(0, 0, 1, 1, 0, 'h300, 0);
    chk("lit_after_ret_pc", 32'(bus.instr_pc), 32'h1E2);
    drive(0, 0, 1, 1, 0, 'h310, 0);
    drive(0, 0, 1, 1, 0, 'h320, 0);
    chk("lit_ovf_before", 32'(bus.stack_ovf), 32'd0);
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("lit_ovf_after", 32'(bus.stack_ovf), 32'd1);
    chk("lit_ret1_addr", 32'(bus.rom_addr), 32'h311);
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("lit_ret2_addr", 32'(bus.rom_addr), 32'h301);
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("lit_ret3_addr", 32'(bus.rom_addr), 32'h301);
    chk("lit_unf_before", 32'(bus.stack_unf), 32'd0);
    drive(0, 0, 1, 0, 0, 'h010, 0);
    chk("lit_unf_after", 32'(bus.stack_unf), 32'd1);
    // Skip inserts one squashed word
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("lit_skip_pc", 32'(bus.instr_pc), 32'h010);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("lit_skipped_pc", 32'(bus.instr_pc), 32'h011);
    chk("lit_skipped_valid", 32'(bus.instr_valid), 32'd0);
    // Stall three cycles at 0x012
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0, 0, 0, 0);
      chk("lit_stall_pc", 32'(bus.instr_pc), 32'h012);
      chk("lit_stall_rom_addr", 32'(bus.rom_addr), 32'h012);
      chk("lit_stall_valid", 32'(bus.instr_valid), 32'd1);
    end
    // Reset during stall restarts at the reset vector
    drive(1, 1, 0, 0, 0, 0, 0);
    chk("lit_rst_stall_addr", 32'(bus.rom_addr), 32'h7FF);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("lit_restart_pc", 32'(bus.instr_pc), 32'h7FF);
    chk("lit_restart_flags", 32'({bus.stack_ovf, bus.stack_unf}), 32'd0);

    // Randomized traffic; redirects only on architectural words
    for (int n = 0; n < 3000; n++) begin
      tick();
      r   = ($urandom_range(0, 199) == 0);
      st  = ($urandom_range(0, 5) == 0);
      v   = m_valid && !r;
      rt  = v && ($urandom_range(0, 9) == 0);
      j   = v && ($urandom_range(0, 6) == 0);
      c   = j && ($urandom_range(0, 1) == 1);
      sk  = v && ($urandom_range(0, 9) == 0);
      tgt = int'($urandom_range(0, 2047));
      apply(r, st, j, c, rt, tgt, sk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
